costas_pi_filter: RTL and testbench
===================================

COSTAS_PI_FILTER -- requirements
Module: costas_pi_filter

Interface
REQ-001 SHALL have parameter ERR_W, default 58, phase-error input width (signed).
REQ-002 SHALL have parameter PD_W, default 24, output phase-control-word width.
REQ-003 SHALL have parameter ACQ_LEN, default 20000, accepted samples spent in acquisition.
REQ-004 SHALL have parameters KP_ACQ_SH 35, KI_ACQ_SH 38, KP_TRK_SH 38, KI_TRK_SH 41: right-shift gains (2^-SH).
REQ-005 SHALL have parameters LOCK_THR, default 2^40, |error| lock threshold, and LOCK_CNT, default 64, consecutive-sample count.
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port err_valid  input  1  pd_err qualifier.
REQ-009 SHALL have port pd_err  input  ERR_W  signed phase-detector error.
REQ-010 SHALL have port freeze  input  1  hold loop output, ignore samples.
REQ-011 SHALL have port pd  output  PD_W  filtered phase-control word.
REQ-012 SHALL have port pd_valid  output  1  one-cycle strobe, pd updated.
REQ-013 SHALL have port state  output  2  00 ACQ, 01 TRACK, 10 HOLD.
REQ-014 SHALL have port locked  output  1  lock indicator.

Function
REQ-015 Sample accepted only when err_valid=1 and state is not HOLD and freeze=0; otherwise x(n-1), y, and counters SHALL hold.
REQ-016 On accepted sample: y(n)=y(n-1)+((x(n)-x(n-1))>>>KP)+(x(n-1)>>>KI), with KP/KI chosen by state at acceptance.
REQ-017 Difference computed at ERR_W+1 bits; all shifts arithmetic (floor toward -inf); terms sign-extended/truncated to PD_W before summing.
REQ-018 y SHALL wrap modulo 2^PD_W (phase is modular); no saturation.
REQ-019 x(n-1) SHALL update to pd_err only on accepted samples.
REQ-020 pd SHALL present updated y and pd_valid SHALL pulse exactly one cycle after acceptance (latency 1); back-to-back samples supported every cycle.
REQ-021 ACQ: sample counter increments per accepted sample; the sample taking counter to ACQ_LEN-1 uses ACQ gains, then state->TRACK next cycle, counter cleared.
REQ-022 TRACK: good-count increments on accepted sample with |pd_err|<LOCK_THR, clears otherwise; reaching LOCK_CNT sets locked=1.
REQ-023 While locked, bad-count increments on |pd_err|>=LOCK_THR, clears otherwise; reaching LOCK_CNT clears locked, state->ACQ, sample counter restarts at 0; y retained.
REQ-024 |most-negative pd_err| SHALL be treated as >= LOCK_THR (no overflow to small value).
REQ-025 freeze=1 in any state: state->HOLD next cycle; sample presented same cycle as freeze rising is not accepted.
REQ-026 freeze falling: HOLD->TRACK if locked=1, else ->ACQ with sample counter preserved; locked unchanged in HOLD.
REQ-027 state encoding 11 unreachable; if entered SHALL recover to ACQ next cycle.

Reset
REQ-028 rst=1 SHALL clear y, pd, x(n-1), all counters, pd_valid, locked; state=ACQ; takes priority over err_valid and freeze.
REQ-029 rst asserted mid-operation SHALL discard any in-flight sample; no pd_valid in cycle after rst.

Verification (ERR_W=16, PD_W=12, KP_ACQ_SH=2, KI_ACQ_SH=4, KP_TRK_SH=4, KI_TRK_SH=6, ACQ_LEN=8, LOCK_THR=8, LOCK_CNT=4)
REQ-030 After reset, pd_err=64 every cycle with err_valid=1 -> pd = 16, 20, 24, 28 on successive pd_valid strobes, state=ACQ.
REQ-031 Continue 64 -> after 8th accepted sample state=01; next increments 1 per sample (64>>>6).
REQ-032 pd_err=-1 constant in ACQ from x(n-1)=-1 -> pd decrements by 1 per sample (floor shift).
REQ-033 Drive y to 4094 then two samples of +4 increment -> pd=4094, 2 (wrap), no error flag.
REQ-034 TRACK, 4 samples |err|=3 -> locked=1; then 3 bad (err=100) plus 1 good -> still locked; then 4 bad -> locked=0, state=00.
REQ-035 freeze=1 with err_valid toggling for 10 cycles -> state=10, pd constant, no pd_valid; release with locked=1 -> state=01; rst during HOLD -> state=00, pd=0.

Source files
------------

// File: rtl/costas_pi_filter_if.sv
// costas_pi_filter_if
// Bundles the sample input and loop-output signals of the Costas-loop
// proportional-integral filter.
//
// Handshake: err_valid qualifies pd_err for one cycle. There is no ready. The
// filter takes every qualified sample except while it is in HOLD or freeze is
// high; refused samples are dropped, not stalled. pd_valid is a one-cycle
// strobe that marks the cycle in which pd carries a newly filtered word.
//
// Signals
//   err_valid : pd_err qualifier                    (master -> slave)
//   pd_err    : signed phase-detector error, ERR_W  (master -> slave)
//   freeze    : hold loop output, ignore samples    (master -> slave)
//   pd        : filtered phase-control word, PD_W   (slave -> master)
//   pd_valid  : one-cycle strobe, pd updated        (slave -> master)
//   state     : 00 ACQ, 01 TRACK, 10 HOLD           (slave -> master)
//   locked    : lock indicator                      (slave -> master)
interface costas_pi_filter_if #(
  parameter int ERR_W = 58,
  parameter int PD_W  = 24
);
  logic                    err_valid;
  logic signed [ERR_W-1:0] pd_err;
  logic                    freeze;
  logic [PD_W-1:0]         pd;
  logic                    pd_valid;
  logic [1:0]              state;
  logic                    locked;

  modport master (
    output err_valid, pd_err, freeze,
    input  pd, pd_valid, state, locked
  );

  modport slave (
    input  err_valid, pd_err, freeze,
    output pd, pd_valid, state, locked
  );
endinterface

// File: rtl/costas_pi_filter.sv
// costas_pi_filter
// Proportional-integral loop filter for a Costas carrier-recovery loop:
//   y(n) = y(n-1) + ((x(n) - x(n-1)) >>> KP) + (x(n-1) >>> KI)
// Gains are right shifts. They are wide during acquisition and narrow while
// tracking. y is a modular phase word, so it wraps and never saturates. A lock
// detector watches |pd_err| against LOCK_THR while the loop is tracking.
//
// Ports
//   clk : sole clock, rising edge
//   rst : synchronous, active-high reset
//   bus : costas_pi_filter_if slave (err_valid, pd_err, freeze in;
//         pd, pd_valid, state, locked out)
module costas_pi_filter #(
  parameter int              ERR_W     = 58,
  parameter int              PD_W      = 24,
  parameter int              ACQ_LEN   = 20000,
  parameter int              KP_ACQ_SH = 35,
  parameter int              KI_ACQ_SH = 38,
  parameter int              KP_TRK_SH = 38,
  parameter int              KI_TRK_SH = 41,
  parameter longint unsigned LOCK_THR  = 64'd1 << 40,
  parameter int              LOCK_CNT  = 64
) (
  input logic               clk,
  input logic               rst,
  costas_pi_filter_if.slave bus
);

  localparam int ACQ_W = (ACQ_LEN > 1) ? $clog2(ACQ_LEN) : 1;
  localparam int LCK_W = $clog2(LOCK_CNT + 1);
  localparam int DIF_W = ERR_W + 1;
  localparam int WM    = (DIF_W > PD_W) ? DIF_W : PD_W;

  typedef enum logic [1:0] {
    ST_ACQ   = 2'b00,
    ST_TRACK = 2'b01,
    ST_HOLD  = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  state_t                  state_q, state_d;
  logic [PD_W-1:0]         y_q;
  logic                    pd_valid_q;
  logic signed [ERR_W-1:0] x_prev_q;
  logic [ACQ_W-1:0]        acq_cnt_q;
  logic [LCK_W-1:0]        good_cnt_q, bad_cnt_q;
  logic                    locked_q;

  // HOLD and the unreachable encoding never take samples.
  logic accept;
  assign accept = bus.err_valid && !bus.freeze &&
                  (state_q == ST_ACQ || state_q == ST_TRACK);

  // The magnitude is taken one bit wider than the error, so the most negative
  // error gives a large positive value instead of wrapping to a small one.
  logic signed [DIF_W-1:0] x_ext, xp_ext, diff;
  logic [DIF_W-1:0]        mag;
  logic                    err_good;
  assign x_ext    = DIF_W'(bus.pd_err);
  assign xp_ext   = DIF_W'(x_prev_q);
  assign diff     = x_ext - xp_ext;
  assign mag      = x_ext[DIF_W-1] ? -x_ext : x_ext;
  assign err_good = 64'(mag) < LOCK_THR;

  // Arithmetic shifts floor toward -inf. Each term is sign-extended to a common
  // width and then cut to PD_W, so the sum wraps modulo 2^PD_W.
  logic signed [DIF_W-1:0] p_sh;
  logic signed [ERR_W-1:0] i_sh;
  logic signed [WM-1:0]    p_wide, i_wide;
  logic [PD_W-1:0]         y_next;
  always_comb begin
    p_sh = diff >>> KP_ACQ_SH;
    i_sh = x_prev_q >>> KI_ACQ_SH;
    if (state_q == ST_TRACK) begin
      p_sh = diff >>> KP_TRK_SH;
      i_sh = x_prev_q >>> KI_TRK_SH;
    end
    p_wide = WM'(p_sh);
    i_wide = WM'(i_sh);
    y_next = y_q + p_wide[PD_W-1:0] + i_wide[PD_W-1:0];
  end

  logic acq_last, good_last, bad_last, trk_acc, gain_lock, lose_lock;
  assign acq_last  = acq_cnt_q == ACQ_W'(ACQ_LEN - 1);
  assign good_last = good_cnt_q == LCK_W'(LOCK_CNT - 1);
  assign bad_last  = bad_cnt_q == LCK_W'(LOCK_CNT - 1);
  assign trk_acc   = accept && state_q == ST_TRACK;
  assign gain_lock = trk_acc && !locked_q && err_good && good_last;
  assign lose_lock = trk_acc && locked_q && !err_good && bad_last;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ACQ;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACQ: begin
        if (bus.freeze)              state_d = ST_HOLD;
        else if (accept && acq_last) state_d = ST_TRACK;
      end
      ST_TRACK: begin
        if (bus.freeze)     state_d = ST_HOLD;
        else if (lose_lock) state_d = ST_ACQ;
      end
      ST_HOLD: begin
        // The acquisition count is kept, so an unlocked loop resumes where it
        // left off.
        if (!bus.freeze) state_d = locked_q ? ST_TRACK : ST_ACQ;
      end
      default: state_d = ST_ACQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q        <= '0;
      pd_valid_q <= 1'b0;
      x_prev_q   <= '0;
      acq_cnt_q  <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      locked_q   <= 1'b0;
    end else begin
      pd_valid_q <= accept;
      if (accept) begin
        y_q      <= y_next;
        x_prev_q <= bus.pd_err;
      end
      if (accept && state_q == ST_ACQ) begin
        if (acq_last) begin
          acq_cnt_q  <= '0;
          good_cnt_q <= '0;
          bad_cnt_q  <= '0;
        end else begin
          acq_cnt_q <= acq_cnt_q + ACQ_W'(1);
        end
      end
      if (trk_acc) begin
        if (!locked_q) begin
          if (!err_good)      good_cnt_q <= '0;
          else if (gain_lock) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            locked_q   <= 1'b1;
          end else            good_cnt_q <= good_cnt_q + LCK_W'(1);
        end else begin
          if (err_good)       bad_cnt_q <= '0;
          else if (lose_lock) begin
            bad_cnt_q  <= '0;
            good_cnt_q <= '0;
            acq_cnt_q  <= '0;
            locked_q   <= 1'b0;
          end else            bad_cnt_q <= bad_cnt_q + LCK_W'(1);
        end
      end
    end
  end

  assign bus.pd       = y_q;
  assign bus.pd_valid = pd_valid_q;
  assign bus.state    = state_q;
  assign bus.locked   = locked_q;

endmodule

// File: tb/tb_costas_pi_filter.sv
// Testbench for costas_pi_filter with a small configuration. Expected values
// are worked out by hand from the filter equation, the acquisition length and
// the lock rules.
module tb_costas_pi_filter;

  localparam int ERR_W = 16;
  localparam int PD_W  = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  costas_pi_filter_if #(.ERR_W(ERR_W), .PD_W(PD_W)) bus ();

  costas_pi_filter #(
    .ERR_W(ERR_W), .PD_W(PD_W), .ACQ_LEN(8),
    .KP_ACQ_SH(2), .KI_ACQ_SH(4), .KP_TRK_SH(4), .KI_TRK_SH(6),
    .LOCK_THR(64'd8), .LOCK_CNT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- scoreboard ----------------
  logic [PD_W-1:0] exp_q[$];
  logic            sb_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_on && bus.pd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb.unexpected_pd_valid", 32'(bus.pd_valid), 0);
      end else begin
        chk("sb.pd", 32'(bus.pd), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- drivers ----------------
  // Drive one cycle at the falling edge; return just after the next rising edge.
  task automatic step(input logic v, input int e, input logic f, input logic r);
    @(negedge clk);
    rst           = r;
    bus.err_valid = v;
    bus.pd_err    = 16'(e);
    bus.freeze    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic samples(input int n, input int e);
    for (int k = 0; k < n; k++) step(1'b1, e, 1'b0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic r;
    logic v;
    int   e;
    logic f;
    int   pd;
    int   pv;
    int   st;
    int   lk;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl[NV];

  initial begin
    bus.err_valid = 1'b0;
    bus.pd_err    = '0;
    bus.freeze    = 1'b0;

    // Reset, then a constant 64: proportional kick 16, then +4 (64>>>4) per sample.
    tbl[0]  = '{1'b1, 1'b0,   0, 1'b0,    0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1,  64, 1'b0,   16, 1, 0, 0};
    tbl[2]  = '{1'b0, 1'b1,  64, 1'b0,   20, 1, 0, 0};
    tbl[3]  = '{1'b0, 1'b1,  64, 1'b0,   24, 1, 0, 0};
    tbl[4]  = '{1'b0, 1'b1,  64, 1'b0,   28, 1, 0, 0};
    tbl[5]  = '{1'b0, 1'b1,  64, 1'b0,   32, 1, 0, 0};
    tbl[6]  = '{1'b0, 1'b1,  64, 1'b0,   36, 1, 0, 0};
    tbl[7]  = '{1'b0, 1'b1,  64, 1'b0,   40, 1, 0, 0};
    // 8th sample still uses acquisition gains, then TRACK: +1 (64>>>6) per sample.
    tbl[8]  = '{1'b0, 1'b1,  64, 1'b0,   44, 1, 1, 0};
    tbl[9]  = '{1'b0, 1'b1,  64, 1'b0,   45, 1, 1, 0};
    tbl[10] = '{1'b0, 1'b1,  64, 1'b0,   46, 1, 1, 0};
    tbl[11] = '{1'b0, 1'b0,  64, 1'b0,   46, 0, 1, 0};
    // Reset wins over a valid sample presented in the same cycle.
    tbl[12] = '{1'b1, 1'b1,  64, 1'b0,    0, 0, 0, 0};
    // -1: first -1 (kick), then -1>>>4 = -1 per sample (floor), wrapping below 0.
    tbl[13] = '{1'b0, 1'b1,  -1, 1'b0, 4095, 1, 0, 0};
    tbl[14] = '{1'b0, 1'b1,  -1, 1'b0, 4094, 1, 0, 0};
    tbl[15] = '{1'b0, 1'b1,  -1, 1'b0, 4093, 1, 0, 0};
    tbl[16] = '{1'b0, 1'b1,  -1, 1'b0, 4092, 1, 0, 0};
    tbl[17] = '{1'b0, 1'b1,  -1, 1'b0, 4091, 1, 0, 0};
    tbl[18] = '{1'b0, 1'b1,  -1, 1'b0, 4090, 1, 0, 0};
    // 19: (20>>>2) + (-1>>>4) = +4 -> 4094; 31: (12>>>2) + (19>>>4) = +4 -> wraps to 2.
    tbl[19] = '{1'b0, 1'b1,  19, 1'b0, 4094, 1, 0, 0};
    tbl[20] = '{1'b0, 1'b1,  31, 1'b0,    2, 1, 1, 0};
    tbl[21] = '{1'b1, 1'b0,   0, 1'b0,    0, 0, 0, 0};

    sb_on = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].pv == 1) exp_q.push_back(PD_W'(tbl[i].pd));
      step(tbl[i].v, tbl[i].e, tbl[i].f, tbl[i].r);
      chk($sformatf("tbl[%0d].pd", i),       32'(bus.pd),       tbl[i].pd);
      chk($sformatf("tbl[%0d].pd_valid", i), 32'(bus.pd_valid), tbl[i].pv);
      chk($sformatf("tbl[%0d].state", i),    32'(bus.state),    tbl[i].st);
      chk($sformatf("tbl[%0d].locked", i),   32'(bus.locked),   tbl[i].lk);
    end
    @(negedge clk);
    #1;
    sb_on = 1'b0;
    chk("sb.drained", 32'(exp_q.size()), 0);

    // ---------------- lock / unlock ----------------
    do_reset();
    samples(8, 0);
    chk("lock.enter_track", 32'(bus.state), 1);
    samples(3, 3);
    chk("lock.three_good", 32'(bus.locked), 0);
    samples(1, 3);
    chk("lock.set", 32'(bus.locked), 1);
    samples(3, 100);
    samples(1, 3);
    chk("lock.held", 32'(bus.locked), 1);
    chk("lock.held_state", 32'(bus.state), 1);
    // (3-100)>>>4 = -7 (floor), 100>>>6 = 1: y goes from 8 to 2.
    chk("lock.floor_pd", 32'(bus.pd), 2);
    samples(3, 100);
    chk("lock.three_bad", 32'(bus.locked), 1);
    samples(1, 100);
    chk("lock.cleared", 32'(bus.locked), 0);
    chk("lock.back_to_acq", 32'(bus.state), 0);
    chk("lock.y_retained", 32'(bus.pd), 11);
    samples(7, 100);
    chk("lock.acq_restart_7", 32'(bus.state), 0);
    samples(1, 100);
    chk("lock.acq_restart_8", 32'(bus.state), 1);

    // ---------------- most-negative error counts as bad ----------------
    do_reset();
    samples(8, 0);
    samples(3, 3);
    samples(1, -32768);
    chk("minneg.not_good", 32'(bus.locked), 0);
    samples(1, 3);
    chk("minneg.count_cleared", 32'(bus.locked), 0);
    samples(3, 3);
    chk("minneg.relock", 32'(bus.locked), 1);

    // ---------------- freeze while locked ----------------
    do_reset();
    samples(8, 0);
    samples(4, 3);
    samples(1, 100);
    chk("frz.pre_pd", 32'(bus.pd), 6);
    for (int i = 0; i < 10; i++) begin
      step(i % 2 == 0, -50, 1'b1, 1'b0);
      chk($sformatf("frz[%0d].state", i),    32'(bus.state),    2);
      chk($sformatf("frz[%0d].pd", i),       32'(bus.pd),       6);
      chk($sformatf("frz[%0d].pd_valid", i), 32'(bus.pd_valid), 0);
      chk($sformatf("frz[%0d].locked", i),   32'(bus.locked),   1);
    end
    step(1'b0, 0, 1'b0, 1'b0);
    chk("frz.release_state", 32'(bus.state), 1);
    chk("frz.release_locked", 32'(bus.locked), 1);
    // x(n-1) is still 100 (held samples were ignored): diff 0, 100>>>6 = 1.
    samples(1, 100);
    chk("frz.resume_pd", 32'(bus.pd), 7);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("frz.hold_again", 32'(bus.state), 2);
    step(1'b0, 0, 1'b1, 1'b1);
    chk("frz.rst_state", 32'(bus.state), 0);
    chk("frz.rst_pd", 32'(bus.pd), 0);
    chk("frz.rst_locked", 32'(bus.locked), 0);
    chk("frz.rst_pd_valid", 32'(bus.pd_valid), 0);

    // ---------------- freeze while acquiring keeps the sample count ----------------
    do_reset();
    samples(5, 0);
    step(1'b1, 0, 1'b1, 1'b0);
    step(1'b1, 0, 1'b1, 1'b0);
    chk("acqfrz.hold", 32'(bus.state), 2);
    step(1'b1, 0, 1'b0, 1'b0);
    chk("acqfrz.release_acq", 32'(bus.state), 0);
    chk("acqfrz.release_no_sample", 32'(bus.pd_valid), 0);
    samples(2, 0);
    chk("acqfrz.seven", 32'(bus.state), 0);
    samples(1, 0);
    chk("acqfrz.eight", 32'(bus.state), 1);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
